// File: rtl/frame_ram_pkg.sv
// Shared defaults, FSM encoding and requester IDs for the frame RAM arbiter.
package frame_ram_pkg;

  localparam int unsigned DefaultDepth = 10000;
  localparam int unsigned DefaultAw    = 16;
  localparam int unsigned DefaultDw    = 24;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StStrobe  = 2'd2,
    StCapture = 2'd3
  } arb_state_e;

  localparam logic IdCam = 1'b0;
  localparam logic IdCpu = 1'b1;

endpackage

// File: rtl/frame_arb_rr.sv
// Two-way round-robin pick: on a conflict the requester not granted last wins.
module frame_arb_rr
  import frame_ram_pkg::*;
(
  input  logic cam_req_i,
  input  logic cpu_req_i,
  input  logic last_grant_i,
  output logic grant_o
);

  always_comb begin
    grant_o = IdCam;
    if (cam_req_i && cpu_req_i) begin
      grant_o = ~last_grant_i;
    end else if (cpu_req_i) begin
      grant_o = IdCpu;
    end
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Shares one frame RAM between camera writes and CPU reads/writes, one access per 4 cycles.
// Define FRAME_ARB_AUTOINC_EN to take the camera address from an internal wrapping pointer.
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = DefaultAw,
  parameter int unsigned DW    = DefaultDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cam_req,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_wdata,
  output logic          cam_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic [AW-1:0] ram_address,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic          ram_en,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out,
  output logic          busy,
  output logic          frame_done
);

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   addr_ext_t;

  localparam addr_ext_t DepthExt = addr_ext_t'(DEPTH);

  arb_state_e     state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_grant_q, last_grant_d;
  logic           err_q, err_d;
  logic           rr_grant;
  logic           fire;
  addr_t          sel_addr;
  logic           sel_err;
  addr_t          cam_addr_eff;
  addr_t          ram_address_q, ram_address_d;
  logic [DW-1:0]  ram_data_in_q, ram_data_in_d;
  logic           ram_rd_q, ram_rd_d;
  logic           ram_wr_q, ram_wr_d;
  logic           ram_en_q, ram_en_d;
  logic           cam_ack_q, cam_ack_d;
  logic           cpu_ack_q, cpu_ack_d;
  logic           cpu_err_q, cpu_err_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;

  frame_arb_rr u_rr (
    .cam_req_i    (cam_req),
    .cpu_req_i    (cpu_req),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    err_d         = err_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    ram_rd_d      = ram_rd_q;
    ram_wr_d      = ram_wr_q;
    ram_en_d      = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    fire          = 1'b0;
    sel_addr      = (rr_grant == IdCam) ? cam_addr_eff : cpu_addr;
    sel_err       = ({1'b0, sel_addr} >= DepthExt);

    unique case (state_q)
      StIdle: begin
        if (cam_req || cpu_req) begin
          state_d       = StSetup;
          grant_d       = rr_grant;
          last_grant_d  = rr_grant;
          err_d         = sel_err;
          ram_address_d = sel_addr;
          ram_data_in_d = (rr_grant == IdCam) ? cam_wdata : cpu_wdata;
          ram_wr_d      = !sel_err && ((rr_grant == IdCam) || cpu_we);
          ram_rd_d      = !sel_err && (rr_grant == IdCpu) && !cpu_we;
        end
      end
      StSetup: begin
        // Out-of-range accesses skip the strobe entirely.
        if (err_q) begin
          state_d = StCapture;
          fire    = 1'b1;
        end else begin
          state_d  = StStrobe;
          ram_en_d = 1'b1;
        end
      end
      StStrobe: begin
        state_d  = StCapture;
        ram_rd_d = 1'b0;
        ram_wr_d = 1'b0;
        fire     = 1'b1;
        if (ram_rd_q) begin
          cpu_rdata_d = ram_data_out;
        end
      end
      StCapture: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    cam_ack_d = fire && (grant_q == IdCam);
    cpu_ack_d = fire && (grant_q == IdCpu);
    cpu_err_d = cpu_ack_d && err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_q       <= IdCam;
      // Last grant starts at cpu so the first conflict goes to cam.
      last_grant_q  <= IdCpu;
      err_q         <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_rd_q      <= 1'b0;
      ram_wr_q      <= 1'b0;
      ram_en_q      <= 1'b0;
      cam_ack_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cpu_err_q     <= 1'b0;
      cpu_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      err_q         <= err_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      ram_rd_q      <= ram_rd_d;
      ram_wr_q      <= ram_wr_d;
      ram_en_q      <= ram_en_d;
      cam_ack_q     <= cam_ack_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_err_q     <= cpu_err_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

`ifdef FRAME_ARB_AUTOINC_EN
  localparam addr_t LastAddr = addr_t'(DEPTH - 1);

  addr_t cam_ptr_q;
  logic  frame_done_q;
  logic  unused_cam_addr;

  // Pointer advances after the ack cycle so it still names the acked address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cam_ptr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= cam_ack_d && (cam_ptr_q == LastAddr);
      if (cam_ack_q) begin
        cam_ptr_q <= (cam_ptr_q == LastAddr) ? '0 : cam_ptr_q + 1'b1;
      end
    end
  end

  assign cam_addr_eff    = cam_ptr_q;
  assign frame_done      = frame_done_q;
  assign unused_cam_addr = ^cam_addr;
`else
  assign cam_addr_eff = cam_addr;
  assign frame_done   = 1'b0;
`endif

  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_rd      = ram_rd_q;
  assign ram_wr      = ram_wr_q;
  assign ram_en      = ram_en_q;
  assign cam_ack     = cam_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_err     = cpu_err_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 10000, meaning the number of pixel words in the frame RAM.
REQ-002 SHALL have parameter AW, default 16, meaning the address width.
REQ-003 SHALL have parameter DW, default 24, meaning the pixel width ({B,G,R} 8 bits each).
REQ-004 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have ports cam_req in 1, cam_addr in AW, cam_wdata in DW, cam_ack out 1: the camera write requester.
REQ-007 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in AW, cpu_wdata in DW, cpu_rdata out DW, cpu_ack out 1, cpu_err out 1: the J1 CPU read/write requester.
REQ-008 SHALL have ports ram_address out AW, ram_rd out 1, ram_wr out 1, ram_en out 1, ram_data_in out DW, ram_data_out in DW: the frame RAM, which samples on the rising edge of ram_en.
REQ-009 SHALL have ports busy out 1 (FSM not IDLE) and frame_done out 1 (one-cycle pulse).

Function
REQ-010 SHALL implement FSM IDLE -> SETUP -> STROBE -> CAPTURE -> IDLE, one cycle per state.
REQ-011 In IDLE, SHALL grant one requester whose req is high; with both high, SHALL grant the one not granted last (round-robin); the first conflict after reset SHALL go to cam.
REQ-012 In SETUP, SHALL register ram_address, ram_rd/ram_wr (cam always writes; cpu writes when cpu_we=1) and ram_data_in, with ram_en=0.
REQ-013 In STROBE, SHALL hold ram_address, ram_rd, ram_wr and ram_data_in stable and drive ram_en=1, for exactly one cycle.
REQ-014 In CAPTURE, SHALL drive ram_en=0, latch ram_data_out into cpu_rdata on a cpu read, and pulse the granted ack for one cycle.
REQ-015 Latency SHALL be fixed: ack is high 3 cycles after the IDLE cycle that sampled req; maximum throughput is 1 access per 4 cycles.
REQ-016 A requester SHALL hold req, addr, we and wdata stable until ack; if req is still high in the cycle after ack, it is a new request.
REQ-017 An address >= DEPTH SHALL NOT strobe the RAM: go SETUP -> CAPTURE with ram_en=0; cpu gets cpu_ack with cpu_err=1; cam gets cam_ack and the write is dropped.
REQ-018 cpu_err SHALL be valid only with cpu_ack and 0 otherwise; cpu_rdata SHALL hold its value until the next cpu read completes.
REQ-019 ram_rd and ram_wr SHALL never both be 1; outside SETUP/STROBE both SHALL be 0.
REQ-020 A req that drops before ack SHALL NOT abort the access in progress; the access completes and ack still pulses.

Reset
REQ-021 rst_n=0 SHALL force IDLE, round-robin pointer=cam, and all outputs 0 (ram_*, acks, cpu_rdata, cpu_err, busy, frame_done) on the next posedge.
REQ-022 Reset mid-access SHALL abandon the access with no ack; a ram_en that was high SHALL fall in the reset cycle.

Configuration
REQ-023 With macro FRAME_ARB_AUTOINC_EN defined, cam_addr SHALL be ignored and an internal pointer SHALL supply the cam address.
REQ-024 With FRAME_ARB_AUTOINC_EN defined, the pointer SHALL be 0 at reset and increment on each cam_ack.
REQ-025 With FRAME_ARB_AUTOINC_EN defined, the pointer SHALL wrap from DEPTH-1 to 0, with frame_done pulsing in the cam_ack cycle of address DEPTH-1.
REQ-026 Without FRAME_ARB_AUTOINC_EN, cam_addr SHALL be used and frame_done SHALL be tied 0.

Structure
REQ-027 Package frame_ram_pkg SHALL hold DEPTH/AW/DW defaults, the FSM state encoding and the requester IDs (CAM=0, CPU=1).
REQ-028 The round-robin pick SHALL be sub-module frame_arb_rr (inputs: two reqs, last-grant bit; output: grant index); all other logic SHALL be in frame_ram_arbiter.

Verification
REQ-029 Single cpu write then read: write addr 5 with 0xA1B2C3, then read addr 5 -> cpu_rdata=0xA1B2C3, each ack 3 cycles after req, ram_en high exactly 1 cycle per access.
REQ-030 cam_req and cpu_req held high together for 16 accesses -> grants alternate cam, cpu, cam ..., 8 each, no ram_rd and ram_wr overlap.
REQ-031 cpu read at addr 10000 -> cpu_ack with cpu_err=1 and ram_en never rises; a following read of addr 9999 -> cpu_err=0.
REQ-032 FRAME_ARB_AUTOINC_EN, 10001 cam writes -> frame_done pulses once at address 9999 and the last write lands at address 0.
REQ-033 Assert rst_n=0 during STROBE -> next cycle IDLE, ram_en=0, no ack; after release a new cpu access completes normally.
